// File: rtl/result_accumulator.sv
// result_accumulator
// Captures 8-bit lane results under valid/ready, sums NSAMP of them into an
// ACC_W-bit frame sum, then presents the sum in parallel and shifts it out
// serially LSB first.
module result_accumulator #(
    parameter int NSAMP = 4,
    parameter int ACC_W = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ena_i,
    input  logic             clr_i,
    input  logic [7:0]       in_word_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [ACC_W-1:0] sum_out_o,
    output logic             ser_out_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             busy_o,
    output logic             overflow_o
);

    localparam int CNT_W = $clog2(NSAMP + 1);
    localparam int BIT_W = $clog2(ACC_W);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   shift_q, shift_d;
    logic [BIT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;

    logic               transfer;
    logic [ACC_W-1:0]   wordExt;
    logic [ACC_W:0]     addFull;

    // Ready is gated by reset so nothing upstream sees a handshake while held in reset.
    assign in_ready_o = ena_i & rst_ni & (state_q != SHIFT);
    assign transfer   = in_valid_i & in_ready_o;
    assign wordExt    = ACC_W'(in_word_i);
    assign addFull    = {1'b0, acc_q} + {1'b0, wordExt};

    assign sum_out_o   = sum_q;
    assign overflow_o  = ovf_q;
    assign ser_out_o   = shift_q[0];
    assign ser_valid_o = (state_q == SHIFT);
    assign ser_last_o  = (state_q == SHIFT) && (bitCnt_q == BIT_W'(ACC_W - 1));
    assign busy_o      = (state_q != IDLE);

    // State register; async reset drops the frame and all outputs at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            bitCnt_q <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic: clr wins over a transfer, and nothing moves without ena.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;
        if (ena_i) begin
            if (clr_i) begin
                state_d  = IDLE;
                acc_d    = '0;
                cnt_d    = '0;
                shift_d  = '0;
                bitCnt_d = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (transfer) begin
                            acc_d = wordExt;
                            cnt_d = CNT_W'(1);
                            ovf_d = 1'b0;
                            if (NSAMP == 1) begin
                                sum_d    = wordExt;
                                shift_d  = wordExt;
                                bitCnt_d = '0;
                                state_d  = SHIFT;
                            end else begin
                                state_d = ACCUM;
                            end
                        end
                    end
                    ACCUM: begin
                        if (transfer) begin
                            acc_d = addFull[ACC_W-1:0];
                            cnt_d = cnt_q + 1'b1;
                            ovf_d = ovf_q | addFull[ACC_W];
                            if (cnt_q == CNT_W'(NSAMP - 1)) begin
                                sum_d    = addFull[ACC_W-1:0];
                                shift_d  = addFull[ACC_W-1:0];
                                bitCnt_d = '0;
                                state_d  = SHIFT;
                            end
                        end
                    end
                    SHIFT: begin
                        shift_d = shift_q >> 1;
                        if (bitCnt_q == BIT_W'(ACC_W - 1)) begin
                            bitCnt_d = '0;
                            state_d  = IDLE;
                        end else begin
                            bitCnt_d = bitCnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/result_accumulator.md
# result_accumulator

Sequential consumer sitting directly downstream of the 2-bit-lane logic stage. Captures its 8-bit result word {v,z,y,x} under a valid/ready handshake and sums NSAMP consecutive words into an ACC_W-bit accumulator. Presents the finished sum in parallel and also shifts it out serially, LSB first, for the pin-limited output path.

## Interface
- NSAMP, default 4: number of words summed per frame, ≥1.
- ACC_W, default 10: accumulator width, ≥8. The defaults hold 4×255 = 1020 without overflow.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ena  in  1  clock enable; when 0 all state holds.
- clr  in  1  synchronous frame abort.
- in_word  in  8  result word from the logic stage, bits [7:6]=v, [5:4]=z, [3:2]=y, [1:0]=x.
- in_valid  in  1  in_word is valid.
- in_ready  out  1  block accepts a word this cycle.
- sum_out  out  ACC_W  last completed frame sum, held until the next frame completes.
- ser_out  out  1  serial sum bit.
- ser_valid  out  1  ser_out is valid.
- ser_last  out  1  marks the final (MSB) serial bit.
- busy  out  1  high in ACCUM or SHIFT.
- overflow  out  1  sticky flag; set if any add carried out of ACC_W in the current or last frame.

## Operation
- States:
  - IDLE: waiting for the first word.
  - ACCUM: frame partially summed.
  - SHIFT: serialising the sum.
- Transfer: occurs on a cycle where in_valid & in_ready & ena.
- in_ready: combinational; equals ena & reset & (state ≠ SHIFT). It does not depend on in_valid.
- IDLE + transfer:
  - acc ← zero-extended in_word; cnt ← 1; overflow ← 0.
  - Next state is ACCUM, or SHIFT directly if NSAMP = 1.
- ACCUM + transfer:
  - acc ← (acc + in_word) mod 2^ACC_W; cnt ← cnt + 1.
  - overflow ← overflow | carry.
- Frame completion: the transfer that brings cnt to NSAMP loads the new sum into sum_out and the shift register, and moves the state to SHIFT.
- SHIFT:
  - Each ena cycle presents one bit: ser_out = shift[0], ser_valid = 1; the register then shifts right.
  - Exactly ACC_W bits are sent.
  - ser_last = 1 on bit ACC_W-1; the following edge returns the state to IDLE.
- Gaps: gaps in in_valid during ACCUM are allowed; acc and cnt hold.
- ena = 0:
  - No transfer, no shift, no state change.
  - ser_valid holds its value and the same bit is re-presented.
- clr = 1 (with ena):
  - Next state IDLE; acc, cnt and shift register cleared; ser_valid/ser_last ← 0.
  - sum_out and overflow retained.
  - clr beats a simultaneous transfer; that word is dropped.
- Arithmetic: unsigned, modulo 2^ACC_W; no saturation.

## Timing
- Reset values (async, immediate on reset = 0):
  - state IDLE; acc, cnt, shift = 0.
  - sum_out = 0, ser_out = 0, ser_valid = 0, ser_last = 0, busy = 0, overflow = 0.
  - in_ready = 0 while reset is low.
- Latency: the last transfer at edge k makes sum_out valid and ser_valid = 1 with bit 0 after edge k.
  - Bit i is presented after edge k+i (no ena stalls); ser_last after edge k+ACC_W-1.
  - in_ready returns after edge k+ACC_W.
- Throughput: one word per cycle in IDLE/ACCUM. Minimum frame period is NSAMP + ACC_W cycles.
- Reset mid-SHIFT or mid-ACCUM: ser_valid drops asynchronously and the partial frame is lost.
- busy rises the cycle after the first transfer (or the frame-completing transfer when NSAMP = 1) and falls the cycle after ser_last.

## Test plan
- Reset check: drive reset = 0 with ena = 1 and in_valid = 1 → all outputs 0 and in_ready = 0; after release, in_ready = 1.
- Basic frame (defaults): words 0x01, 0x02, 0x03, 0x04 on 4 consecutive cycles →
  - sum_out = 0x00A the cycle after the 4th word.
  - Serial bits LSB-first: 0,1,0,1,0,0,0,0,0,0, with ser_last on the 10th.
  - overflow = 0; in_ready = 0 for exactly 10 cycles.
- Max and stalls: 4×0xFF with in_valid gaps and one ena = 0 cycle during ACCUM and one during SHIFT →
  - sum_out = 0x3FC; the stalled serial bit repeats; the sequence is otherwise unchanged.
- clr collision: 2 words accepted, then clr = 1 with in_valid = 1 →
  - Word dropped; state IDLE; sum_out keeps the prior value.
  - A following 4-word frame 0x10 each gives 0x040.
- Reset mid-SHIFT: assert reset at serial bit 3 → ser_valid = 0 immediately; the next full frame sums correctly from 0.
- Overflow (NSAMP = 2, ACC_W = 8): words 0xFF, 0x02 → sum_out = 0x01, overflow = 1. The next frame's first transfer clears overflow.
